// File: rtl/adpll_sequencer_if.sv
// Signal bundle between the ADPLL sequencer and its PFD, DCO and tracking controller.
// The master drives run/PFD/controller inputs; the slave is the sequencer itself.
interface adpll_sequencer_if;
    logic       enable;
    logic       p_up;
    logic       p_down;
    logic [4:0] ctrl_dco_code;
    logic       ctrl_freq_lock;
    logic [4:0] dco_code;
    logic [4:0] coarse_code;
    logic       ctrl_reset;
    logic [2:0] state;
    logic       locked;
    logic       lock_lost;
    logic       fail;

    modport master (
        output enable, p_up, p_down, ctrl_dco_code, ctrl_freq_lock,
        input  dco_code, coarse_code, ctrl_reset, state, locked, lock_lost, fail
    );

    modport slave (
        input  enable, p_up, p_down, ctrl_dco_code, ctrl_freq_lock,
        output dco_code, coarse_code, ctrl_reset, state, locked, lock_lost, fail
    );
endinterface

// File: rtl/adpll_sequencer.sv
// ADPLL bring-up sequencer: 5-bit binary coarse search on PFD votes, then hands the
// DCO to the tracking controller and supervises lock, loss of lock and retries.
module adpll_sequencer #(
    parameter int SETTLE_CYCLES = 8,
    parameter int EVAL_CYCLES   = 16,
    parameter int LOCK_CYCLES   = 32,
    parameter int UNLOCK_CYCLES = 4,
    parameter int TRACK_TIMEOUT = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic              ref_clk,
    input  logic              reset_n,
    adpll_sequencer_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SET    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_EVAL   = 3'd3;
    localparam logic [2:0] S_DECIDE = 3'd4;
    localparam logic [2:0] S_TRACK  = 3'd5;
    localparam logic [2:0] S_LOCKED = 3'd6;
    localparam logic [2:0] S_FAIL   = 3'd7;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EVAL_LAST    = CNT_W'(EVAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TRACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST  = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRY);

    logic [2:0]       state_q,    state_d;
    logic [2:0]       idx_q,      idx_d;
    logic [4:0]       coarse_q,   coarse_d;
    logic [CNT_W-1:0] timer_q,    timer_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [4:0]       up_cnt_q,   up_cnt_d;
    logic [4:0]       dn_cnt_q,   dn_cnt_d;
    logic [7:0]       retry_q,    retry_d;
    logic             lock_lost_q, lock_lost_d;

    logic tracking;
    assign tracking = (state_q == S_TRACK) || (state_q == S_LOCKED);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        coarse_d    = coarse_q;
        timer_d     = timer_q;
        lock_cnt_d  = lock_cnt_q;
        up_cnt_d    = up_cnt_q;
        dn_cnt_d    = dn_cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        // Dropping enable wins over every in-state event; coarse_code is kept for inspection.
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d  = S_SET;
                    coarse_d = '0;
                    idx_d    = 3'd4;
                    retry_d  = '0;
                end
                S_SET: begin
                    coarse_d[idx_q] = 1'b1;
                    timer_d         = '0;
                    state_d         = S_SETTLE;
                end
                S_SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_d  = S_EVAL;
                        timer_d  = '0;
                        up_cnt_d = '0;
                        dn_cnt_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (bus.p_up && !bus.p_down && up_cnt_q != 5'd31) up_cnt_d = up_cnt_q + 1'b1;
                    if (bus.p_down && !bus.p_up && dn_cnt_q != 5'd31) dn_cnt_d = dn_cnt_q + 1'b1;
                    if (timer_q == EVAL_LAST) state_d = S_DECIDE;
                    else                      timer_d = timer_q + 1'b1;
                end
                S_DECIDE: begin
                    if (dn_cnt_q > up_cnt_q) coarse_d[idx_q] = 1'b0;
                    if (idx_q != 3'd0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SET;
                    end else begin
                        state_d    = S_TRACK;
                        timer_d    = '0;
                        lock_cnt_d = '0;
                    end
                end
                S_TRACK: begin
                    if (bus.ctrl_freq_lock && lock_cnt_q == LOCK_LAST) begin
                        state_d    = S_LOCKED;
                        lock_cnt_d = '0;
                        retry_d    = '0;
                    end else begin
                        lock_cnt_d = bus.ctrl_freq_lock ? lock_cnt_q + 1'b1 : '0;
                        if (timer_q == TIMEOUT_LAST) begin
                            retry_d = retry_q + 1'b1;
                            if (retry_q + 8'd1 == RETRY_LIMIT) begin
                                state_d = S_FAIL;
                            end else begin
                                state_d  = S_SET;
                                idx_d    = 3'd4;
                                coarse_d = '0;
                            end
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    if (bus.ctrl_freq_lock) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q == UNLOCK_LAST) begin
                        lock_lost_d = 1'b1;
                        lock_cnt_d  = '0;
                        state_d     = S_SET;
                        idx_d       = 3'd4;
                        coarse_d    = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd4;
            coarse_q    <= '0;
            timer_q     <= '0;
            lock_cnt_q  <= '0;
            up_cnt_q    <= '0;
            dn_cnt_q    <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            coarse_q    <= coarse_d;
            timer_q     <= timer_d;
            lock_cnt_q  <= lock_cnt_d;
            up_cnt_q    <= up_cnt_d;
            dn_cnt_q    <= dn_cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.coarse_code = coarse_q;
    assign bus.dco_code    = tracking ? bus.ctrl_dco_code : coarse_q;
    assign bus.ctrl_reset  = !tracking;
    assign bus.locked      = (state_q == S_LOCKED);
    assign bus.fail        = (state_q == S_FAIL);
    assign bus.lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_adpll_sequencer.sv
// Directed bench for adpll_sequencer: table of PFD patterns with expected coarse codes,
// plus hand-written lock, unlock, timeout, priority and asynchronous reset sequences.
module tb_adpll_sequencer;

    logic ref_clk = 1'b0;
    logic reset_n = 1'b0;

    adpll_sequencer_if bus ();

    adpll_sequencer #(
        .SETTLE_CYCLES(8), .EVAL_CYCLES(16), .LOCK_CYCLES(32),
        .UNLOCK_CYCLES(4), .TRACK_TIMEOUT(256), .MAX_RETRY(3)
    ) dut (
        .ref_clk(ref_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 ref_clk = ~ref_clk;

    // PFD stimulus modes
    localparam int M_UP = 0, M_DN = 1, M_ALT = 2, M_BOTH = 3, M_NONE = 4, M_DCO = 5;

    typedef struct {
        int         mode;
        int         boundary;
        logic [4:0] exp_coarse;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " state"},      32'(bus.state),       0);
        check({tag, " dco_code"},   32'(bus.dco_code),    0);
        check({tag, " coarse"},     32'(bus.coarse_code), 0);
        check({tag, " ctrl_reset"}, 32'(bus.ctrl_reset),  1);
        check({tag, " locked"},     32'(bus.locked),      0);
        check({tag, " lock_lost"},  32'(bus.lock_lost),   0);
        check({tag, " fail"},       32'(bus.fail),        0);
    endtask

    task automatic drive_pfd(input int mode, input int boundary, input bit phase);
        case (mode)
            M_UP:    begin bus.p_up = 1'b1;  bus.p_down = 1'b0;   end
            M_DN:    begin bus.p_up = 1'b0;  bus.p_down = 1'b1;   end
            M_ALT:   begin bus.p_up = phase; bus.p_down = ~phase; end
            M_BOTH:  begin bus.p_up = 1'b1;  bus.p_down = 1'b1;   end
            M_NONE:  begin bus.p_up = 1'b0;  bus.p_down = 1'b0;   end
            default: begin
                bus.p_up   = (int'(bus.dco_code) < boundary);
                bus.p_down = ~bus.p_up;
            end
        endcase
    endtask

    task automatic go_idle();
        @(negedge ref_clk);
        bus.enable = 1'b0;
        @(posedge ref_clk);
        #1;
    endtask

    // Starts from IDLE; returns with #1 after the edge that entered TRACK (or the bound expired).
    task automatic run_search(input int mode, input int boundary, output int cycles);
        bit phase;
        phase = 1'b0;
        @(negedge ref_clk);
        bus.enable = 1'b1;
        drive_pfd(mode, boundary, phase);
        @(posedge ref_clk);
        #1;
        check("enter SET", 32'(bus.state), 1);
        cycles = 0;
        while (bus.state !== 3'd5 && cycles < 2000) begin
            @(negedge ref_clk);
            phase = ~phase;
            drive_pfd(mode, boundary, phase);
            @(posedge ref_clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   cyc;
        int   n;

        vecs[0] = '{M_UP,   0,  5'd31};
        vecs[1] = '{M_DN,   0,  5'd0};
        vecs[2] = '{M_ALT,  0,  5'd31};
        vecs[3] = '{M_BOTH, 0,  5'd31};
        vecs[4] = '{M_NONE, 0,  5'd31};
        vecs[5] = '{M_DCO,  13, 5'd12};
        vecs[6] = '{M_DCO,  20, 5'd19};
        vecs[7] = '{M_DCO,  1,  5'd0};
        vecs[8] = '{M_DCO,  32, 5'd31};

        bus.enable         = 1'b0;
        bus.p_up           = 1'b0;
        bus.p_down         = 1'b0;
        bus.ctrl_dco_code  = 5'd10;
        bus.ctrl_freq_lock = 1'b0;

        #12;
        check_reset_outputs("por");
        @(negedge ref_clk);
        reset_n = 1'b1;
        @(posedge ref_clk);
        #1;
        check("idle after release", 32'(bus.state), 0);

        // Coarse search vectors
        foreach (vecs[i]) begin
            go_idle();
            run_search(vecs[i].mode, vecs[i].boundary, cyc);
            check($sformatf("vec%0d search cycles", i), 32'(cyc), 130);
            check($sformatf("vec%0d coarse", i), 32'(bus.coarse_code), 32'(vecs[i].exp_coarse));
            check($sformatf("vec%0d dco in TRACK", i), 32'(bus.dco_code), 10);
            check($sformatf("vec%0d ctrl_reset", i), 32'(bus.ctrl_reset), 0);
            go_idle();
            check($sformatf("vec%0d idle", i), 32'(bus.state), 0);
            check($sformatf("vec%0d coarse held", i), 32'(bus.coarse_code), 32'(vecs[i].exp_coarse));
            check($sformatf("vec%0d idle dco", i), 32'(bus.dco_code), 32'(vecs[i].exp_coarse));
        end

        // Lock after 32 cycles, 3 low cycles tolerated, 4 low cycles drop lock
        go_idle();
        run_search(M_UP, 0, cyc);
        bus.ctrl_freq_lock = 1'b1;
        repeat (31) @(posedge ref_clk);
        #1;
        check("lock 31 state", 32'(bus.state), 5);
        check("lock 31 locked", 32'(bus.locked), 0);
        @(posedge ref_clk);
        #1;
        check("lock 32 state", 32'(bus.state), 6);
        check("lock 32 locked", 32'(bus.locked), 1);
        check("locked dco", 32'(bus.dco_code), 10);
        bus.ctrl_freq_lock = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        check("low3 lock_lost", 32'(bus.lock_lost), 0);
        check("low3 state", 32'(bus.state), 6);
        bus.ctrl_freq_lock = 1'b1;
        @(posedge ref_clk);
        #1;
        bus.ctrl_freq_lock = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        check("relow3 state", 32'(bus.state), 6);
        @(posedge ref_clk);
        #1;
        check("low4 lock_lost", 32'(bus.lock_lost), 1);
        check("low4 state", 32'(bus.state), 1);
        check("low4 ctrl_reset", 32'(bus.ctrl_reset), 1);
        check("low4 locked", 32'(bus.locked), 0);
        check("low4 coarse", 32'(bus.coarse_code), 0);
        @(posedge ref_clk);
        #1;
        check("lock_lost pulse end", 32'(bus.lock_lost), 0);

        // enable=0 coinciding with the unlock event wins
        go_idle();
        run_search(M_UP, 0, cyc);
        bus.ctrl_freq_lock = 1'b1;
        repeat (32) @(posedge ref_clk);
        #1;
        check("prio locked", 32'(bus.locked), 1);
        bus.ctrl_freq_lock = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        bus.enable = 1'b0;
        @(posedge ref_clk);
        #1;
        check("prio state", 32'(bus.state), 0);
        check("prio lock_lost", 32'(bus.lock_lost), 0);
        check("prio locked clear", 32'(bus.locked), 0);
        check("prio coarse held", 32'(bus.coarse_code), 31);

        // Three track timeouts end in FAIL
        run_search(M_UP, 0, cyc);
        n = 0;
        while (bus.state !== 3'd7 && n < 3000) begin
            @(posedge ref_clk);
            #1;
            n++;
        end
        check("timeout cycles to FAIL", 32'(n), 1028);
        check("fail flag", 32'(bus.fail), 1);
        check("fail ctrl_reset", 32'(bus.ctrl_reset), 1);
        check("fail dco", 32'(bus.dco_code), 31);
        repeat (5) @(posedge ref_clk);
        #1;
        check("fail held", 32'(bus.state), 7);
        bus.enable = 1'b0;
        @(posedge ref_clk);
        #1;
        check("fail exit state", 32'(bus.state), 0);
        check("fail exit flag", 32'(bus.fail), 0);

        // Asynchronous reset during EVAL
        @(negedge ref_clk);
        bus.enable = 1'b1;
        bus.p_up   = 1'b1;
        bus.p_down = 1'b0;
        repeat (10) @(posedge ref_clk);
        #1;
        check("reach EVAL", 32'(bus.state), 3);
        check("EVAL dco trial", 32'(bus.dco_code), 16);
        @(negedge ref_clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst eval");
        bus.enable = 1'b0;
        @(negedge ref_clk);
        reset_n = 1'b1;
        @(posedge ref_clk);
        #1;
        check("post rst idle", 32'(bus.state), 0);

        // Asynchronous reset while LOCKED
        run_search(M_UP, 0, cyc);
        bus.ctrl_freq_lock = 1'b1;
        repeat (32) @(posedge ref_clk);
        #1;
        check("pre rst locked", 32'(bus.locked), 1);
        @(negedge ref_clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst locked");
        bus.enable         = 1'b0;
        bus.ctrl_freq_lock = 1'b0;
        @(negedge ref_clk);
        reset_n = 1'b1;
        @(posedge ref_clk);
        #1;
        check("post rst2 idle", 32'(bus.state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adpll_sequencer.md
ADPLL_SEQUENCER -- requirements
Module: adpll_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8, DCO settle wait per trial bit.
REQ-002 SHALL have parameter EVAL_CYCLES, default 16, PFD sampling window per trial bit (max 31).
REQ-003 SHALL have parameter LOCK_CYCLES, default 32, consecutive ctrl_freq_lock cycles needed to declare lock.
REQ-004 SHALL have parameter UNLOCK_CYCLES, default 4, consecutive ctrl_freq_lock-low cycles that declare loss of lock.
REQ-005 SHALL have parameter TRACK_TIMEOUT, default 256, maximum cycles in TRACK without lock.
REQ-006 SHALL have parameter MAX_RETRY, default 3, consecutive timeouts before FAIL.
REQ-007 SHALL have ports: ref_clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-008 SHALL have ports: enable in 1 run request; p_up in 1 PFD up (DCO slow); p_down in 1 PFD down (DCO fast).
REQ-009 SHALL have ports: ctrl_dco_code in 5 tracking-controller code; ctrl_freq_lock in 1 tracking-controller lock.
REQ-010 SHALL have ports: dco_code out 5 DCO control; coarse_code out 5 search result; ctrl_reset out 1 holds tracking controller in reset.
REQ-011 SHALL have ports: state out 3 FSM state; locked out 1; lock_lost out 1 one-cycle pulse; fail out 1.

Function
REQ-012 SHALL use one clock and an asynchronous, active-low reset; all state updates occur on rising ref_clk.
REQ-013 SHALL implement states IDLE=0, SET=1, SETTLE=2, EVAL=3, DECIDE=4, TRACK=5, LOCKED=6, FAIL=7, reported on state.
REQ-014 IDLE: enable=1 moves to SET, clears coarse_code to 0, sets bit index to 4, and clears the retry count.
REQ-015 SET (1 cycle): sets coarse_code[idx]=1, then moves to SETTLE.
REQ-016 SETTLE lasts SETTLE_CYCLES cycles; EVAL then lasts EVAL_CYCLES cycles.
REQ-017 EVAL: cycle with p_up=1,p_down=0 increments up_cnt; p_down=1,p_up=0 increments dn_cnt; both or neither counts nothing; counters clear on entering EVAL and saturate at 31.
REQ-018 DECIDE (1 cycle): dn_cnt>up_cnt clears coarse_code[idx], otherwise keeps it (tie keeps); idx>0 decrements idx and goes to SET; idx=0 goes to TRACK.
REQ-019 One search SHALL take exactly 5*(2+SETTLE_CYCLES+EVAL_CYCLES) cycles, 130 at default.
REQ-020 dco_code SHALL equal coarse_code in IDLE/SET/SETTLE/EVAL/DECIDE/FAIL and ctrl_dco_code in TRACK/LOCKED.
REQ-021 ctrl_reset SHALL be 1 in all states except TRACK and LOCKED.
REQ-022 TRACK: ctrl_freq_lock high for LOCK_CYCLES consecutive cycles moves to LOCKED and clears the retry count; any low cycle restarts the count.
REQ-023 TRACK: TRACK_TIMEOUT cycles without lock increments the retry count; if it equals MAX_RETRY go to FAIL, else restart search (SET, idx=4, coarse_code=0).
REQ-024 LOCKED: locked=1; ctrl_freq_lock low for UNLOCK_CYCLES consecutive cycles pulses lock_lost for one cycle, clears locked, and restarts search.
REQ-025 FAIL: fail=1, held until enable=0.
REQ-026 enable=0 in any state SHALL move to IDLE next cycle, clear locked/fail, and hold coarse_code.
REQ-027 Simultaneous timeout/unlock and enable=0: enable=0 SHALL take priority.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, dco_code=0, coarse_code=0, ctrl_reset=1, locked=0, lock_lost=0, fail=0, all counters 0.
REQ-029 Reset asserted mid-search or mid-lock SHALL abandon the operation; resumption requires enable after release.

Verification
REQ-030 p_up=1,p_down=0 constant, enable=1 -> TRACK entered 130 cycles after SET, coarse_code=31.
REQ-031 p_down=1,p_up=0 constant -> coarse_code=0; alternating pattern yielding tie every bit -> coarse_code=31.
REQ-032 DCO model boundary at 13 (p_up if code<13, else p_down) -> coarse_code=12.
REQ-033 In TRACK, ctrl_freq_lock=1 -> locked=1 after 32 cycles; then low for 3 cycles -> no lock_lost; then low 4 cycles -> lock_lost pulse, state=SET, ctrl_reset=1.
REQ-034 ctrl_freq_lock=0 permanently -> three 256-cycle timeouts, state=FAIL, fail=1; enable=0 -> IDLE, fail=0.
REQ-035 reset_n=0 mid-EVAL and in LOCKED -> all outputs at reset values within the same cycle, no clock required.
